seg_scan_mux: RTL

//  Downstream display stage for the digital clock. Takes the five 7-segment codes
//  (sec_l, sec_h, min_l, min_h, hour) and time-multiplexes them onto one shared

---
 rtl/seg_scan_mux_if.sv | 32 +++
 rtl/seg_scan_mux.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - digit-code inputs and multiplexed segment outputs of the display scanner
// blink_mask exists only when SCAN_BLINK_EN is defined.
interface seg_scan_mux_if;
  logic [6:0] in_sec_l;
  logic [6:0] in_sec_h;
  logic [6:0] in_min_l;
  logic [6:0] in_min_h;
  logic [6:0] in_hour;
  logic [3:0] brightness;
`ifdef SCAN_BLINK_EN
  logic [4:0] blink_mask;
`endif
  logic [6:0] seg;
  logic [4:0] dig_en;
  logic       frame_start;

  modport master (
    output in_sec_l, in_sec_h, in_min_l, in_min_h, in_hour, brightness,
`ifdef SCAN_BLINK_EN
    output blink_mask,
`endif
    input  seg, dig_en, frame_start
  );

  modport slave (
    input  in_sec_l, in_sec_h, in_min_l, in_min_h, in_hour, brightness,
`ifdef SCAN_BLINK_EN
    input  blink_mask,
`endif
    output seg, dig_en, frame_start
  );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - five-digit 7-segment scanner with PWM brightness and per-frame shadowing
// Optional digit blinking is enabled by defining SCAN_BLINK_EN.
module seg_scan_mux #(
  parameter int TICK_DIV   = 625
`ifdef SCAN_BLINK_EN
  , parameter int BLINK_HALF = 500
`endif
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_mux_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    dig_q, dig_d;
  logic [6:0]    sh_code_q [5];
  logic [6:0]    sh_code_d [5];
  logic [3:0]    sh_bright_q, sh_bright_d;
  logic [6:0]    seg_q, seg_d;
  logic [4:0]    dig_en_q, dig_en_d;
  logic          frame_start_q, frame_start_d;

  logic          presc_wrap;
  logic          sub_wrap;
  logic          frame_end;
  logic [4:0]    dig_oh;
  logic [6:0]    code_sel;
  logic          lit;

`ifdef SCAN_BLINK_EN
  localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_HALF - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [4:0]    sh_mask_q, sh_mask_d;
`endif

  always_comb begin
    presc_wrap = (presc_q == PRESC_MAX);
    sub_wrap   = presc_wrap && (sub_q == 4'd15);
    frame_end  = sub_wrap && (dig_q == 3'd4);

    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    sub_d   = presc_wrap ? sub_q + 4'd1 : sub_q;
    dig_d   = dig_q;
    if (sub_wrap) begin
      dig_d = (dig_q == 3'd4) ? 3'd0 : dig_q + 3'd1;
    end

    // Shadow everything the decode uses at the frame boundary so a frame is never torn.
    sh_code_d   = sh_code_q;
    sh_bright_d = sh_bright_q;
    if (frame_end) begin
      sh_code_d[0] = bus.in_sec_l;
      sh_code_d[1] = bus.in_sec_h;
      sh_code_d[2] = bus.in_min_l;
      sh_code_d[3] = bus.in_min_h;
      sh_code_d[4] = bus.in_hour;
      sh_bright_d  = bus.brightness;
    end

    case (dig_q)
      3'd0:    begin dig_oh = 5'b00001; code_sel = sh_code_q[0]; end
      3'd1:    begin dig_oh = 5'b00010; code_sel = sh_code_q[1]; end
      3'd2:    begin dig_oh = 5'b00100; code_sel = sh_code_q[2]; end
      3'd3:    begin dig_oh = 5'b01000; code_sel = sh_code_q[3]; end
      3'd4:    begin dig_oh = 5'b10000; code_sel = sh_code_q[4]; end
      default: begin dig_oh = 5'b00000; code_sel = 7'd0;         end
    endcase

    // sub=15 never satisfies sub<brightness, giving dark time around every digit change.
    lit = (sub_q < sh_bright_q);

`ifdef SCAN_BLINK_EN
    fcnt_d    = fcnt_q;
    phase_d   = phase_q;
    sh_mask_d = sh_mask_q;
    if (frame_end) begin
      sh_mask_d = bus.blink_mask;
      if (fcnt_q == FCNT_MAX) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    if (phase_q && ((sh_mask_q & dig_oh) != 5'd0)) begin
      lit = 1'b0;
    end
`endif

    seg_d         = lit ? code_sel : 7'd0;
    dig_en_d      = lit ? dig_oh : 5'd0;
    frame_start_d = (presc_q == '0) && (sub_q == 4'd0) && (dig_q == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      sub_q         <= 4'd0;
      dig_q         <= 3'd0;
      sh_code_q     <= '{default: 7'd0};
      sh_bright_q   <= 4'd0;
      seg_q         <= 7'd0;
      dig_en_q      <= 5'd0;
      frame_start_q <= 1'b0;
`ifdef SCAN_BLINK_EN
      fcnt_q        <= '0;
      phase_q       <= 1'b0;
      sh_mask_q     <= 5'd0;
`endif
    end else begin
      presc_q       <= presc_d;
      sub_q         <= sub_d;
      dig_q         <= dig_d;
      sh_code_q     <= sh_code_d;
      sh_bright_q   <= sh_bright_d;
      seg_q         <= seg_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
`ifdef SCAN_BLINK_EN
      fcnt_q        <= fcnt_d;
      phase_q       <= phase_d;
      sh_mask_q     <= sh_mask_d;
`endif
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dig_en      = dig_en_q;
  assign bus.frame_start = frame_start_q;

endmodule
